alu_arbiter: RTL and testbench

- Shares one combinational `alu` instance between two requesters, e.g. the execute stage and the branch/AGU path.
- Each requester uses a valid/ready request channel and its own valid/ready response channel.
- Arbitration is round-robin. The single result is registered and held until the owning requester accepts it.
- A retired-operation counter is kept for performance monitoring.

---
 rtl/alu_arbiter.sv | 146 ++++++++++++++
 tb/tb_alu_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// The result is registered and held until its owner accepts it.
module alu (
   input  logic        op,
   input  logic        op_imm,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] t
);

   logic [4:0] shamt;
   logic       alt;
   logic       en;

   assign shamt = b[4:0];
   assign alt   = funct7[5];
   assign en    = op | op_imm;

   // Immediate forms have no SUB; funct7 there is part of the immediate.
   always_comb begin
      t = '0;
      if (en) begin
         case (funct3)
            3'b000: t = (alt && !op_imm) ? a - b : a + b;
            3'b001: t = a << shamt;
            3'b010: t = {31'b0, $signed(a) < $signed(b)};
            3'b011: t = {31'b0, a < b};
            3'b100: t = a ^ b;
            3'b101: t = alt ? 32'($signed(a) >>> shamt) : a >> shamt;
            3'b110: t = a | b;
            3'b111: t = a & b;
            default: t = '0;
         endcase
      end
   end

endmodule

module alu_arbiter #(
   parameter int NREQ  = 2,
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ-1:0]      req_op,
   input  logic [NREQ-1:0]      req_op_imm,
   input  logic [NREQ*3-1:0]    req_funct3,
   input  logic [NREQ*7-1:0]    req_funct7,
   input  logic [NREQ*32-1:0]   req_a,
   input  logic [NREQ*32-1:0]   req_b,
   output logic [NREQ-1:0]      rsp_valid,
   input  logic [NREQ-1:0]      rsp_ready,
   output logic [31:0]          rsp_t,
   output logic [CNT_W-1:0]     ops_done
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t      state;
   logic        own;
   logic        last;

   logic        retire;
   logic        slot_free;
   logic        g;
   logic        fire;

   logic        s_op;
   logic        s_op_imm;
   logic [2:0]  s_f3;
   logic [6:0]  s_f7;
   logic [31:0] s_a;
   logic [31:0] s_b;
   logic [31:0] alu_t;

   assign retire    = (state == HOLD) && rsp_ready[own];
   assign slot_free = (state == IDLE) || retire;

   // Contested grant goes to whoever did not win last time.
   always_comb begin
      if (req_valid[0] && req_valid[1])
         g = ~last;
      else if (req_valid[1])
         g = 1'b1;
      else
         g = 1'b0;
   end

   assign fire = slot_free && (|req_valid);

   always_comb begin
      req_ready    = '0;
      req_ready[g] = fire;
   end

   assign rsp_valid[0] = (state == HOLD) && !own;
   assign rsp_valid[1] = (state == HOLD) &&  own;

   assign s_op     = g ? req_op[1]         : req_op[0];
   assign s_op_imm = g ? req_op_imm[1]     : req_op_imm[0];
   assign s_f3     = g ? req_funct3[5:3]   : req_funct3[2:0];
   assign s_f7     = g ? req_funct7[13:7]  : req_funct7[6:0];
   assign s_a      = g ? req_a[63:32]      : req_a[31:0];
   assign s_b      = g ? req_b[63:32]      : req_b[31:0];

   alu u_alu (
      .op     (s_op),
      .op_imm (s_op_imm),
      .funct3 (s_f3),
      .funct7 (s_f7),
      .a      (s_a),
      .b      (s_b),
      .t      (alu_t)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         own      <= 1'b0;
         last     <= 1'b1;
         rsp_t    <= '0;
         ops_done <= '0;
      end else begin
         if (retire)
            ops_done <= ops_done + CNT_ONE;
         if (fire) begin
            rsp_t <= alu_t;
            own   <= g;
            last  <= g;
            state <= HOLD;
         end else if (retire) begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a CNT_W=4 twin shares the stimulus
// so the counter wrap can be observed.
module tb_alu_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_op;
   logic [1:0]  req_op_imm;
   logic [5:0]  req_funct3;
   logic [13:0] req_funct7;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [1:0]  rsp_ready;

   logic [1:0]  req_ready;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_t;
   logic [31:0] ops_done;

   logic [1:0]  w_req_ready;
   logic [1:0]  w_rsp_valid;
   logic [31:0] w_rsp_t;
   logic [3:0]  w_ops_done;

   int n_chk;
   int n_err;

   alu_arbiter #(.NREQ(2), .CNT_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_op_imm (req_op_imm),
      .req_funct3 (req_funct3),
      .req_funct7 (req_funct7),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_t      (rsp_t),
      .ops_done   (ops_done)
   );

   alu_arbiter #(.NREQ(2), .CNT_W(4)) dut_w (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (w_req_ready),
      .req_op     (req_op),
      .req_op_imm (req_op_imm),
      .req_funct3 (req_funct3),
      .req_funct7 (req_funct7),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (w_rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_t      (w_rsp_t),
      .ops_done   (w_ops_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input int i, input logic v, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a,
                        input logic [31:0] b);
      req_valid[i]          = v;
      req_funct3[i*3 +: 3]  = f3;
      req_funct7[i*7 +: 7]  = f7;
      req_a[i*32 +: 32]     = a;
      req_b[i*32 +: 32]     = b;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [2:0]  b2b_f3  [4];
   logic [31:0] b2b_exp [4];

   initial begin
      n_chk      = 0;
      n_err      = 0;
      rst_n      = 1'b0;
      req_valid  = '0;
      req_op     = 2'b11;
      req_op_imm = 2'b00;
      req_funct3 = '0;
      req_funct7 = '0;
      req_a      = '0;
      req_b      = '0;
      rsp_ready  = '0;

      b2b_f3[0] = 3'b000; b2b_exp[0] = 32'h2000_1504;
      b2b_f3[1] = 3'b110; b2b_exp[1] = 32'h2000_1504;
      b2b_f3[2] = 3'b111; b2b_exp[2] = 32'h0;
      b2b_f3[3] = 3'b011; b2b_exp[3] = 32'h0;

      #3;
      check("rst_rsp_valid", {30'b0, rsp_valid}, 32'h0);
      check("rst_rsp_t", rsp_t, 32'h0);
      check("rst_ops_done", ops_done, 32'h0);
      check("rst_req_ready", {30'b0, req_ready}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single requester: ADD then SUB
      @(negedge clk);
      drive(0, 1'b1, 3'b000, 7'h00, 32'd20, 32'd7);
      #1 check("add_req_ready", {30'b0, req_ready}, 32'h1);
      step();
      check("add_rsp_valid", {30'b0, rsp_valid}, 32'h1);
      check("add_rsp_t", rsp_t, 32'd27);
      drive(0, 1'b1, 3'b000, 7'h20, 32'd20, 32'd7);
      rsp_ready = 2'b01;
      #1 check("sub_req_ready", {30'b0, req_ready}, 32'h1);
      step();
      drive(0, 1'b0, 3'b000, 7'h00, 32'd0, 32'd0);
      check("sub_rsp_t", rsp_t, 32'd13);
      check("sub_ops_done", ops_done, 32'd1);
      step();
      check("single_idle", {30'b0, rsp_valid}, 32'h0);
      check("single_ops_done", ops_done, 32'd2);
      rsp_ready = 2'b00;

      // Contested from reset
      pulse_reset();
      @(negedge clk);
      drive(0, 1'b1, 3'b010, 7'h00, -32'sd100, 32'd4);
      drive(1, 1'b1, 3'b101, 7'h20, -32'sd100, 32'd2);
      #1 check("arb1_req_ready", {30'b0, req_ready}, 32'h1);
      step();
      drive(0, 1'b0, 3'b000, 7'h00, 32'd0, 32'd0);
      check("arb1_rsp_valid", {30'b0, rsp_valid}, 32'h1);
      check("arb1_slt", rsp_t, 32'd1);
      check("arb1_hold_ready", {30'b0, req_ready}, 32'h0);
      rsp_ready = 2'b01;
      #1 check("arb2_req_ready", {30'b0, req_ready}, 32'h2);
      step();
      check("arb2_rsp_valid", {30'b0, rsp_valid}, 32'h2);
      check("arb2_sra", rsp_t, 32'hFFFF_FFE7);
      check("arb2_ops_done", ops_done, 32'd1);
      rsp_ready = 2'b10;
      drive(0, 1'b1, 3'b000, 7'h00, 32'd1, 32'd2);
      drive(1, 1'b1, 3'b000, 7'h00, 32'd5, 32'd5);
      #1 check("arb3_req_ready", {30'b0, req_ready}, 32'h1);
      step();
      drive(0, 1'b0, 3'b000, 7'h00, 32'd0, 32'd0);
      check("arb3_rsp_valid", {30'b0, rsp_valid}, 32'h1);
      check("arb3_rsp_t", rsp_t, 32'd3);
      rsp_ready = 2'b01;
      step();
      drive(1, 1'b0, 3'b000, 7'h00, 32'd0, 32'd0);
      check("arb4_rsp_valid", {30'b0, rsp_valid}, 32'h2);
      check("arb4_rsp_t", rsp_t, 32'd10);
      rsp_ready = 2'b10;
      step();
      check("arb_idle", {30'b0, rsp_valid}, 32'h0);
      check("arb_ops_done", ops_done, 32'd4);
      rsp_ready = 2'b00;

      // Backpressure; last==1 so req0 wins
      drive(0, 1'b1, 3'b100, 7'h00, 32'd20, 32'd7);
      drive(1, 1'b1, 3'b000, 7'h00, 32'd100, 32'd1);
      #1 check("bp_req_ready", {30'b0, req_ready}, 32'h1);
      step();
      drive(0, 1'b0, 3'b000, 7'h00, 32'd0, 32'd0);
      for (int c = 0; c < 3; c++) begin
         rsp_ready = (c == 1) ? 2'b10 : 2'b00;
         #1;
         check("bp_rsp_t", rsp_t, 32'd19);
         check("bp_rsp_valid", {30'b0, rsp_valid}, 32'h1);
         check("bp_req_ready_hold", {30'b0, req_ready}, 32'h0);
         step();
      end
      rsp_ready = 2'b01;
      #1 check("bp_release_ready", {30'b0, req_ready}, 32'h2);
      step();
      drive(1, 1'b0, 3'b000, 7'h00, 32'd0, 32'd0);
      check("bp_next_valid", {30'b0, rsp_valid}, 32'h2);
      check("bp_next_t", rsp_t, 32'd101);
      rsp_ready = 2'b10;
      step();
      check("bp_ops_done", ops_done, 32'd6);
      rsp_ready = 2'b00;

      // Back-to-back from requester 0
      pulse_reset();
      @(negedge clk);
      rsp_ready = 2'b01;
      for (int k = 0; k < 4; k++) begin
         drive(0, 1'b1, b2b_f3[k], 7'h00, 32'h2000_1000, 32'h0000_0504);
         #1 check("b2b_req_ready", {30'b0, req_ready}, 32'h1);
         step();
         check("b2b_rsp_valid", {30'b0, rsp_valid}, 32'h1);
         check("b2b_rsp_t", rsp_t, b2b_exp[k]);
      end
      drive(0, 1'b0, 3'b000, 7'h00, 32'd0, 32'd0);
      step();
      check("b2b_idle", {30'b0, rsp_valid}, 32'h0);
      check("b2b_ops_done", ops_done, 32'd4);
      rsp_ready = 2'b00;

      // Asynchronous reset while holding
      drive(0, 1'b1, 3'b000, 7'h00, 32'd9, 32'd9);
      step();
      drive(0, 1'b0, 3'b000, 7'h00, 32'd0, 32'd0);
      check("mid_hold_valid", {30'b0, rsp_valid}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {30'b0, rsp_valid}, 32'h0);
      check("mid_rst_ops", ops_done, 32'h0);
      check("mid_rst_t", rsp_t, 32'h0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      drive(0, 1'b1, 3'b000, 7'h00, 32'd1, 32'd1);
      drive(1, 1'b1, 3'b000, 7'h00, 32'd2, 32'd2);
      #1 check("post_rst_grant", {30'b0, req_ready}, 32'h1);
      step();
      drive(0, 1'b0, 3'b000, 7'h00, 32'd0, 32'd0);
      drive(1, 1'b0, 3'b000, 7'h00, 32'd0, 32'd0);
      check("post_rst_t", rsp_t, 32'd2);

      // Counter wrap: 17 retires from requester 1
      pulse_reset();
      @(negedge clk);
      rsp_ready = 2'b10;
      drive(1, 1'b1, 3'b000, 7'h00, 32'd3, 32'd4);
      for (int k = 0; k < 17; k++) step();
      drive(1, 1'b0, 3'b000, 7'h00, 32'd0, 32'd0);
      step();
      check("wrap_ops_w4", {28'b0, w_ops_done}, 32'd1);
      check("wrap_ops_w32", ops_done, 32'd17);
      check("wrap_w_t", w_rsp_t, 32'd7);
      rsp_ready = 2'b00;

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
